// File: rtl/plic_boot_config_if.sv
// AXI4 write-master bundle between the PLIC boot sequencer and the PLIC slave port.
// The read channel is reduced to the two tie-off signals the sequencer drives.
interface plic_boot_config_if #(
   parameter int AXI_ID_WIDTH   = 10,
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 64
);
   logic [AXI_ID_WIDTH-1:0]     awid;
   logic [AXI_ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]                  awlen;
   logic [2:0]                  awsize;
   logic [1:0]                  awburst;
   logic                        awvalid;
   logic                        awready;
   logic [AXI_DATA_WIDTH-1:0]   wdata;
   logic [AXI_DATA_WIDTH/8-1:0] wstrb;
   logic                        wlast;
   logic                        wvalid;
   logic                        wready;
   logic [AXI_ID_WIDTH-1:0]     bid;
   logic [1:0]                  bresp;
   logic                        bvalid;
   logic                        bready;
   logic                        arvalid;
   logic                        rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      output wdata, wstrb, wlast, wvalid, bready, arvalid, rready,
      input  awready, wready, bid, bresp, bvalid
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      input  wdata, wstrb, wlast, wvalid, bready, arvalid, rready,
      output awready, wready, bid, bresp, bvalid
   );
endinterface

// File: rtl/plic_boot_config.sv
// Boot-time PLIC configuration sequencer: on start, issues one 32-bit AXI write
// per source priority, then threshold + enable per context, one at a time,
// and reports done (and a sticky error if any B response was not OKAY).
module plic_boot_config #(
   parameter int          AXI_ID_WIDTH      = 10,
   parameter int          AXI_ADDR_WIDTH    = 64,
   parameter int          AXI_DATA_WIDTH    = 64,
   parameter int          NUMBER_INTERRUPTS = 4,
   parameter int          NUM_CONTEXTS      = 2,
   parameter logic [63:0] PLIC_BASE         = 64'h0C00_0000,
   parameter logic [31:0] SRC_PRIORITY      = 32'd1
) (
   input  logic               aclk,
   input  logic               areset,
   input  logic               start_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               error_o,
   plic_boot_config_if.master m_axi
);
   localparam int TOTAL = NUMBER_INTERRUPTS + 2 * NUM_CONTEXTS;
   localparam int KW    = $clog2(TOTAL);
   localparam logic [KW-1:0] K_LAST = KW'(TOTAL - 1);
   localparam logic [KW-1:0] K_N    = KW'(NUMBER_INTERRUPTS);
   // Sources 1..N map to enable bits 1..N; bit 0 is the reserved source 0.
   localparam logic [31:0] EN_MASK  = ((32'd1 << NUMBER_INTERRUPTS) - 32'd1) << 1;
   localparam logic [AXI_ADDR_WIDTH-1:0] BASE    = AXI_ADDR_WIDTH'(PLIC_BASE);
   localparam logic [AXI_ADDR_WIDTH-1:0] THR_OFS = AXI_ADDR_WIDTH'(32'h0020_0000);
   localparam logic [AXI_ADDR_WIDTH-1:0] EN_OFS  = AXI_ADDR_WIDTH'(32'h0000_2000);
   localparam logic [AXI_ADDR_WIDTH-1:0] ONE     = AXI_ADDR_WIDTH'(1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_B, S_DONE} state_t;

   state_t                    state_q, state_d;
   logic [KW-1:0]             k_q, k_d;
   logic                      aw_pend_q, aw_pend_d;
   logic                      w_pend_q, w_pend_d;
   logic                      err_q, err_d;
   logic [KW-1:0]             j;
   logic [AXI_ADDR_WIDTH-1:0] addr;
   logic [31:0]               val;
   logic                      unused_bid;

   assign unused_bid = ^m_axi.bid;

   // Write-list decode: address and value depend only on k, so both stay
   // stable for as long as the channel valids are held.
   always_comb begin
      j    = k_q - K_N;
      addr = BASE;
      val  = SRC_PRIORITY;
      if (k_q < K_N) begin
         addr = BASE + ((AXI_ADDR_WIDTH'(k_q) + ONE) << 2);
      end else if (!j[0]) begin
         addr = BASE + THR_OFS + (AXI_ADDR_WIDTH'(j[KW-1:1]) << 12);
         val  = 32'd0;
      end else begin
         addr = BASE + EN_OFS + (AXI_ADDR_WIDTH'(j[KW-1:1]) << 7);
         val  = EN_MASK;
      end
   end

   // State, write index, per-channel pending flags and sticky error.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         aw_pend_q <= aw_pend_d;
         w_pend_q  <= w_pend_d;
         err_q     <= err_d;
      end
   end

   // Next-state logic; AW and W retire independently, B is awaited only
   // after both have been accepted.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      aw_pend_d = aw_pend_q;
      w_pend_d  = w_pend_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d   = S_ISSUE;
               k_d       = '0;
               err_d     = 1'b0;
               aw_pend_d = 1'b1;
               w_pend_d  = 1'b1;
            end
         end
         S_ISSUE: begin
            aw_pend_d = aw_pend_q & ~m_axi.awready;
            w_pend_d  = w_pend_q & ~m_axi.wready;
            if (!aw_pend_d && !w_pend_d) state_d = S_WAIT_B;
         end
         S_WAIT_B: begin
            if (m_axi.bvalid) begin
               err_d = err_q | (m_axi.bresp != 2'b00);
               if (k_q == K_LAST) begin
                  state_d = S_DONE;
               end else begin
                  state_d   = S_ISSUE;
                  k_d       = k_q + 1'b1;
                  aw_pend_d = 1'b1;
                  w_pend_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy_o  = (state_q == S_ISSUE) || (state_q == S_WAIT_B);
   assign done_o  = (state_q == S_DONE);
   assign error_o = err_q;

   assign m_axi.awid    = AXI_ID_WIDTH'(0);
   assign m_axi.awaddr  = addr;
   assign m_axi.awlen   = 8'd0;
   assign m_axi.awsize  = 3'b010;
   assign m_axi.awburst = 2'b01;
   assign m_axi.awvalid = aw_pend_q;
   assign m_axi.wdata   = AXI_DATA_WIDTH'({val, val});
   assign m_axi.wstrb   = addr[2] ? 8'hF0 : 8'h0F;
   assign m_axi.wlast   = 1'b1;
   assign m_axi.wvalid  = w_pend_q;
   assign m_axi.bready  = (state_q == S_WAIT_B);
   assign m_axi.arvalid = 1'b0;
   assign m_axi.rready  = 1'b1;
endmodule

// File: tb/tb_plic_boot_config.sv
// Bench for plic_boot_config: a configurable AXI slave for the default
// instance (N=4, C=2) and an always-ready slave for the N=31, C=1 instance.
module tb_plic_boot_config;
   localparam logic [63:0] BASE = 64'h0C00_0000;

   typedef struct {
      logic [63:0] addr;
      logic [31:0] val;
   } exp_t;

   logic aclk = 1'b0;
   logic areset;
   logic start0, busy0, done0, err0;
   logic start1, busy1, done1, err1;
   always #5 aclk = ~aclk;

   plic_boot_config_if #(.AXI_ID_WIDTH(10), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64)) ifm ();
   plic_boot_config_if #(.AXI_ID_WIDTH(10), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64)) ifb ();

   plic_boot_config #(.NUMBER_INTERRUPTS(4), .NUM_CONTEXTS(2)) dut0 (
      .aclk(aclk), .areset(areset), .start_i(start0), .busy_o(busy0),
      .done_o(done0), .error_o(err0), .m_axi(ifm));

   plic_boot_config #(.NUMBER_INTERRUPTS(31), .NUM_CONTEXTS(1)) dut1 (
      .aclk(aclk), .areset(areset), .start_i(start1), .busy_o(busy1),
      .done_o(done1), .error_o(err1), .m_axi(ifb));

   int checks = 0;
   int failures = 0;
   exp_t exp_q[$];
   logic [63:0] obs_a[$], obs_d[$], obs1_a[$], obs1_d[$];
   logic [7:0]  obs_s[$], obs1_s[$];
   exp_t e;
   logic [135:0] got, want;

   // ---------------- slave model for dut0 ----------------
   int aw_dly[8];
   int w_dly[8];
   int err_idx;
   int aw_cnt, w_cnt, wr_idx, viol;
   logic aw_got, w_got, s_bvalid, pav, pwv;
   logic [1:0] s_bresp;
   logic [63:0] pa, pd;
   logic [7:0] ps;
   logic s_awh, s_wh;
   logic [7:0] vbits;

   assign ifm.awready = (aw_cnt >= aw_dly[wr_idx % 8]);
   assign ifm.wready  = (w_cnt >= w_dly[wr_idx % 8]);
   assign ifm.bid     = '0;
   assign ifm.bresp   = s_bresp;
   assign ifm.bvalid  = s_bvalid;
   assign s_awh = ifm.awvalid & ifm.awready;
   assign s_wh  = ifm.wvalid & ifm.wready;
   assign vbits[0] = ifm.awvalid && (ifm.awid != 0 || ifm.awlen != 0 || ifm.awsize != 3'b010 || ifm.awburst != 2'b01);
   assign vbits[1] = ifm.wvalid && !ifm.wlast;
   assign vbits[2] = pav && (!ifm.awvalid || ifm.awaddr != pa);
   assign vbits[3] = pwv && (!ifm.wvalid || ifm.wdata != pd || ifm.wstrb != ps);
   assign vbits[4] = ifm.bready && !(aw_got && w_got);
   assign vbits[5] = s_awh && aw_got;
   assign vbits[6] = s_wh && w_got;
   assign vbits[7] = ifm.arvalid || !ifm.rready;

   // Slave: delayed readies, B one cycle after both channels, protocol watch.
   always @(posedge aclk) begin
      if (areset) begin
         aw_cnt <= 0; w_cnt <= 0; wr_idx <= 0; aw_got <= 1'b0; w_got <= 1'b0;
         s_bvalid <= 1'b0; s_bresp <= 2'b00; pav <= 1'b0; pwv <= 1'b0;
      end else begin
         viol <= viol + $countones(vbits);
         aw_cnt <= s_awh ? 0 : (ifm.awvalid ? aw_cnt + 1 : aw_cnt);
         w_cnt  <= s_wh ? 0 : (ifm.wvalid ? w_cnt + 1 : w_cnt);
         pav <= ifm.awvalid && !s_awh; pa <= ifm.awaddr;
         pwv <= ifm.wvalid && !s_wh;   pd <= ifm.wdata; ps <= ifm.wstrb;
         if (s_awh) begin aw_got <= 1'b1; obs_a.push_back(ifm.awaddr); end
         if (s_wh) begin w_got <= 1'b1; obs_d.push_back(ifm.wdata); obs_s.push_back(ifm.wstrb); end
         if (s_bvalid && ifm.bready) begin
            s_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; wr_idx <= wr_idx + 1;
         end else if (!s_bvalid && (aw_got || s_awh) && (w_got || s_wh)) begin
            s_bvalid <= 1'b1;
            s_bresp  <= ((wr_idx % 8) == err_idx) ? 2'b10 : 2'b00;
         end
      end
   end

   // ---------------- always-ready slave for dut1 ----------------
   logic b1v;
   assign ifb.awready = 1'b1;
   assign ifb.wready  = 1'b1;
   assign ifb.bid     = '0;
   assign ifb.bresp   = 2'b00;
   assign ifb.bvalid  = b1v;

   // Capture dut1 beats and answer each with OKAY on the following cycle.
   always @(posedge aclk) begin
      if (areset) begin
         b1v <= 1'b0;
      end else begin
         if (ifb.awvalid) obs1_a.push_back(ifb.awaddr);
         if (ifb.wvalid) begin obs1_d.push_back(ifb.wdata); obs1_s.push_back(ifb.wstrb); end
         if (b1v && ifb.bready) b1v <= 1'b0;
         else if (ifb.awvalid && ifb.wvalid) b1v <= 1'b1;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_run(input int n, input int c);
      exp_t x;
      for (int s = 1; s <= n; s++) begin
         x.addr = BASE + 64'(4 * s); x.val = 32'd1; exp_q.push_back(x);
      end
      for (int i = 0; i < c; i++) begin
         x.addr = BASE + 64'h20_0000 + 64'(i * 4096); x.val = 32'd0; exp_q.push_back(x);
         x.addr = BASE + 64'h2000 + 64'(i * 128); x.val = 32'((64'd2 << n) - 64'd2); exp_q.push_back(x);
      end
   endtask

   task automatic pulse_start0();
      @(negedge aclk); start0 = 1'b1;
      @(negedge aclk); start0 = 1'b0;
   endtask

   task automatic wait_run0(output int cyc);
      int t = 0;
      cyc = 0;
      while (ifm.awvalid !== 1'b1 && t < 100) begin @(negedge aclk); t++; end
      while (done0 !== 1'b1 && t < 3000) begin @(negedge aclk); cyc++; t++; end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      checks++;
      if ({busy0, done0, err0, ifm.awvalid, ifm.wvalid, ifm.bready} !== 6'b0) begin
         failures++; $display("FAIL reset_outputs got=%b want=000000",
            {busy0, done0, err0, ifm.awvalid, ifm.wvalid, ifm.bready});
      end
      checks++;
      if ({ifm.arvalid, ifm.rready} !== 2'b01) begin
         failures++; $display("FAIL reset_read_ties got=%b want=01", {ifm.arvalid, ifm.rready});
      end
      checks++;
      if ({busy1, done1, err1, ifb.awvalid} !== 4'b0) begin
         failures++; $display("FAIL reset_dut1 got=%b want=0000", {busy1, done1, err1, ifb.awvalid});
      end
   endtask

   task automatic test_default_run();
      int cyc, v0;
      v0 = viol;
      push_run(4, 2);
      pulse_start0();
      wait_run0(cyc);
      checks++;
      if ({done0, err0, busy0} !== 3'b100) begin
         failures++; $display("FAIL default_status got=%b want=100", {done0, err0, busy0});
      end
      checks++;
      if (cyc !== 16) begin failures++; $display("FAIL default_latency got=%0d want=16", cyc); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         want = {e.addr, e.val, e.val, e.addr[2] ? 8'hF0 : 8'h0F};
         got = '0;
         if (obs_a.size() > 0 && obs_d.size() > 0 && obs_s.size() > 0)
            got = {obs_a.pop_front(), obs_d.pop_front(), obs_s.pop_front()};
         checks++;
         if (got !== want) begin failures++; $display("FAIL default_write got=%h want=%h", got, want); end
      end
      checks++;
      if (obs_a.size() + obs_d.size() !== 0) begin
         failures++; $display("FAIL default_extra got=%0d want=0", obs_a.size() + obs_d.size());
      end
      checks++;
      if (viol !== v0) begin failures++; $display("FAIL default_protocol got=%0d want=%0d", viol, v0); end
   endtask

   task automatic test_skewed();
      int cyc, v0;
      v0 = viol;
      aw_dly[0] = 0; w_dly[0] = 3;
      aw_dly[1] = 2; w_dly[1] = 0;
      push_run(4, 2);
      pulse_start0();
      wait_run0(cyc);
      checks++;
      if ({done0, err0} !== 2'b10) begin failures++; $display("FAIL skew_status got=%b want=10", {done0, err0}); end
      checks++;
      if (cyc !== 21) begin failures++; $display("FAIL skew_latency got=%0d want=21", cyc); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         want = {e.addr, e.val, e.val, e.addr[2] ? 8'hF0 : 8'h0F};
         got = '0;
         if (obs_a.size() > 0 && obs_d.size() > 0 && obs_s.size() > 0)
            got = {obs_a.pop_front(), obs_d.pop_front(), obs_s.pop_front()};
         checks++;
         if (got !== want) begin failures++; $display("FAIL skew_write got=%h want=%h", got, want); end
      end
      checks++;
      if (viol !== v0 || obs_a.size() + obs_d.size() !== 0) begin
         failures++; $display("FAIL skew_protocol viol=%0d want=%0d left=%0d", viol, v0, obs_a.size() + obs_d.size());
      end
      aw_dly[0] = 0; w_dly[0] = 0; aw_dly[1] = 0; w_dly[1] = 0;
   endtask

   task automatic test_error();
      int cyc;
      err_idx = 2;
      push_run(4, 2);
      pulse_start0();
      wait_run0(cyc);
      checks++;
      if ({done0, err0} !== 2'b11) begin failures++; $display("FAIL err_status got=%b want=11", {done0, err0}); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         want = {e.addr, e.val, e.val, e.addr[2] ? 8'hF0 : 8'h0F};
         got = '0;
         if (obs_a.size() > 0 && obs_d.size() > 0 && obs_s.size() > 0)
            got = {obs_a.pop_front(), obs_d.pop_front(), obs_s.pop_front()};
         checks++;
         if (got !== want) begin failures++; $display("FAIL err_write got=%h want=%h", got, want); end
      end
      err_idx = -1;
      push_run(4, 2);
      pulse_start0();
      checks++;
      if ({busy0, done0, err0} !== 3'b100) begin
         failures++; $display("FAIL err_clear_on_start got=%b want=100", {busy0, done0, err0});
      end
      wait_run0(cyc);
      checks++;
      if ({done0, err0} !== 2'b10) begin failures++; $display("FAIL err_rerun got=%b want=10", {done0, err0}); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         want = {e.addr, e.val, e.val, e.addr[2] ? 8'hF0 : 8'h0F};
         got = '0;
         if (obs_a.size() > 0 && obs_d.size() > 0 && obs_s.size() > 0)
            got = {obs_a.pop_front(), obs_d.pop_front(), obs_s.pop_front()};
         checks++;
         if (got !== want) begin failures++; $display("FAIL rerun_write got=%h want=%h", got, want); end
      end
   endtask

   task automatic test_start_busy();
      int t, v0, n1;
      v0 = viol;
      push_run(4, 2);
      push_run(4, 2);
      @(negedge aclk); start0 = 1'b1;
      @(negedge aclk);
      t = 0;
      while (done0 !== 1'b1 && t < 3000) begin @(negedge aclk); t++; end
      n1 = obs_a.size();
      checks++;
      if (done0 !== 1'b1 || n1 !== 8) begin
         failures++; $display("FAIL busy_first_run done=%b writes=%0d want done=1 writes=8", done0, n1);
      end
      @(negedge aclk);
      checks++;
      if ({busy0, done0} !== 2'b10) begin failures++; $display("FAIL busy_restart got=%b want=10", {busy0, done0}); end
      start0 = 1'b0;
      t = 0;
      while (done0 !== 1'b1 && t < 3000) begin @(negedge aclk); t++; end
      checks++;
      if (done0 !== 1'b1 || obs_a.size() !== 16) begin
         failures++; $display("FAIL busy_second_run done=%b writes=%0d want done=1 writes=16", done0, obs_a.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         want = {e.addr, e.val, e.val, e.addr[2] ? 8'hF0 : 8'h0F};
         got = '0;
         if (obs_a.size() > 0 && obs_d.size() > 0 && obs_s.size() > 0)
            got = {obs_a.pop_front(), obs_d.pop_front(), obs_s.pop_front()};
         checks++;
         if (got !== want) begin failures++; $display("FAIL busy_write got=%h want=%h", got, want); end
      end
      checks++;
      if (viol !== v0) begin failures++; $display("FAIL busy_protocol got=%0d want=%0d", viol, v0); end
   endtask

   task automatic test_midrun_reset();
      int t, cyc;
      logic stayed;
      push_run(4, 2);
      pulse_start0();
      t = 0;
      while (!(ifm.bready === 1'b1 && (wr_idx % 8) == 4) && t < 200) begin @(negedge aclk); t++; end
      checks++;
      if (ifm.bready !== 1'b1) begin failures++; $display("FAIL midrun_reach_b5 got=%b want=1", ifm.bready); end
      areset = 1'b1;
      @(negedge aclk);
      areset = 1'b0;
      checks++;
      if ({busy0, done0, err0, ifm.awvalid, ifm.wvalid, ifm.bready} !== 6'b0) begin
         failures++; $display("FAIL midrun_reset_outputs got=%b want=000000",
            {busy0, done0, err0, ifm.awvalid, ifm.wvalid, ifm.bready});
      end
      stayed = 1'b1;
      repeat (5) begin
         @(negedge aclk);
         if ({busy0, done0, err0, ifm.awvalid, ifm.wvalid, ifm.bready} !== 6'b0) stayed = 1'b0;
      end
      checks++;
      if (stayed !== 1'b1) begin failures++; $display("FAIL midrun_quiet got=%b want=1", stayed); end
      for (int i = 0; i < 5; i++) begin
         e = exp_q.pop_front();
         want = {e.addr, e.val, e.val, e.addr[2] ? 8'hF0 : 8'h0F};
         got = '0;
         if (obs_a.size() > 0 && obs_d.size() > 0 && obs_s.size() > 0)
            got = {obs_a.pop_front(), obs_d.pop_front(), obs_s.pop_front()};
         checks++;
         if (got !== want) begin failures++; $display("FAIL midrun_write got=%h want=%h", got, want); end
      end
      exp_q.delete();
      checks++;
      if (obs_a.size() + obs_d.size() !== 0) begin
         failures++; $display("FAIL midrun_extra got=%0d want=0", obs_a.size() + obs_d.size());
      end
      push_run(4, 2);
      pulse_start0();
      wait_run0(cyc);
      checks++;
      if ({done0, err0} !== 2'b10 || cyc !== 16) begin
         failures++; $display("FAIL midrun_rerun got=%b cyc=%0d want=10 cyc=16", {done0, err0}, cyc);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         want = {e.addr, e.val, e.val, e.addr[2] ? 8'hF0 : 8'h0F};
         got = '0;
         if (obs_a.size() > 0 && obs_d.size() > 0 && obs_s.size() > 0)
            got = {obs_a.pop_front(), obs_d.pop_front(), obs_s.pop_front()};
         checks++;
         if (got !== want) begin failures++; $display("FAIL midrun_rerun_write got=%h want=%h", got, want); end
      end
   endtask

   task automatic test_boundary();
      int t, cyc, idx;
      push_run(31, 1);
      @(negedge aclk); start1 = 1'b1;
      @(negedge aclk); start1 = 1'b0;
      t = 0; cyc = 0;
      while (ifb.awvalid !== 1'b1 && t < 100) begin @(negedge aclk); t++; end
      while (done1 !== 1'b1 && t < 3000) begin @(negedge aclk); cyc++; t++; end
      checks++;
      if ({done1, err1, busy1} !== 3'b100 || cyc !== 66) begin
         failures++; $display("FAIL bound_status got=%b cyc=%0d want=100 cyc=66", {done1, err1, busy1}, cyc);
      end
      checks++;
      if (obs1_a.size() !== 33) begin failures++; $display("FAIL bound_count got=%0d want=33", obs1_a.size()); end
      checks++;
      if (obs1_a.size() > 30 && obs1_a[30] !== 64'h0C00_007C) begin
         failures++; $display("FAIL bound_last_prio got=%h want=000000000c00007c", obs1_a[30]);
      end
      checks++;
      if (obs1_d.size() > 32 && obs1_d[32] !== 64'hFFFF_FFFE_FFFF_FFFE) begin
         failures++; $display("FAIL bound_enable got=%h want=fffffffefffffffe", obs1_d[32]);
      end
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         want = {e.addr, e.val, e.val, e.addr[2] ? 8'hF0 : 8'h0F};
         got = '0;
         if (obs1_a.size() > 0 && obs1_d.size() > 0 && obs1_s.size() > 0)
            got = {obs1_a.pop_front(), obs1_d.pop_front(), obs1_s.pop_front()};
         checks++;
         if (got !== want) begin failures++; $display("FAIL bound_write[%0d] got=%h want=%h", idx, got, want); end
         idx++;
      end
   endtask

   initial begin
      areset = 1'b1; start0 = 1'b0; start1 = 1'b0; err_idx = -1; viol = 0;
      for (int i = 0; i < 8; i++) begin aw_dly[i] = 0; w_dly[i] = 0; end
      repeat (3) @(negedge aclk);
      areset = 1'b0;
      test_reset();
      test_default_run();
      test_skewed();
      test_error();
      test_start_busy();
      test_midrun_reset();
      test_boundary();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end
endmodule
